// File: rtl/hdlverifier_jtag_register_bank_if.sv
// Request/response bus between the JTAG command decoder (master) and the
// user register bank (slave).
interface hdlverifier_jtag_register_bank_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) ();
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_write;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic [DATA_WIDTH/8-1:0] req_be;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [DATA_WIDTH-1:0]   rsp_rdata;
  logic                    rsp_error;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_error
  );
endinterface

// File: rtl/hdlverifier_jtag_register_bank.sv
// JTAG user register bank: NUM_REGS write registers, NUM_REGS input/snapshot
// registers and a CTRL/STATUS register behind a one-outstanding req/rsp bus.
module hdlverifier_jtag_register_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 4,
  parameter int ADDR_WIDTH = 5,
  parameter int SNAP_MODE  = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  hdlverifier_jtag_register_bank_if.slave bus,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] user_data_in,
  output logic [NUM_REGS*DATA_WIDTH-1:0] user_data_out,
  output logic [NUM_REGS-1:0]            user_wr_strobe
);

  localparam int BE_W = DATA_WIDTH / 8;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RESP = 1'b1;
  localparam logic [ADDR_WIDTH-1:0] CTRL_ADDR = ADDR_WIDTH'(2 * NUM_REGS);

  logic [0:0]            state_r;
  logic                  req_ready_r;
  logic                  rsp_valid_r;
  logic                  rsp_error_r;
  logic [DATA_WIDTH-1:0] rsp_rdata_r;
  logic [DATA_WIDTH-1:0] wr_reg_r [NUM_REGS];
  logic [DATA_WIDTH-1:0] snap_r   [NUM_REGS];
  logic [NUM_REGS-1:0]   strobe_r;
  logic                  sticky_r;
  logic [7:0]            err_cnt_r;

  logic                  accept_s;
  logic                  hit_ctrl_s;
  logic                  oor_s;
  logic                  snap_trig_s;
  logic                  clr_s;
  logic [NUM_REGS-1:0]   wsel_s;
  logic [DATA_WIDTH-1:0] rdata_s;
  logic [DATA_WIDTH-1:0] merge_s;
  logic [DATA_WIDTH-1:0] status_s;
  logic [DATA_WIDTH-1:0] in_val_s [NUM_REGS];

  assign accept_s = bus.req_valid & req_ready_r;

  // Input-register view: live inputs or the last coherent snapshot.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_chan
    assign in_val_s[g] = (SNAP_MODE != 0) ? snap_r[g]
                                          : user_data_in[g*DATA_WIDTH +: DATA_WIDTH];
    assign user_data_out[g*DATA_WIDTH +: DATA_WIDTH] = wr_reg_r[g];
  end

  // Address decode, read mux and byte-enable merge for the current request.
  always_comb begin
    rdata_s          = '0;
    wsel_s           = '0;
    status_s         = '0;
    status_s[15:8]   = err_cnt_r;
    status_s[1]      = sticky_r;
    hit_ctrl_s       = (bus.req_addr == CTRL_ADDR);
    oor_s            = (bus.req_addr > CTRL_ADDR);
    for (int i = 0; i < NUM_REGS; i++) begin
      wsel_s[i] = (bus.req_addr == ADDR_WIDTH'(i));
      rdata_s   = rdata_s | ({DATA_WIDTH{wsel_s[i]}} & wr_reg_r[i]);
      rdata_s   = rdata_s | ({DATA_WIDTH{bus.req_addr == ADDR_WIDTH'(NUM_REGS + i)}} & in_val_s[i]);
    end
    rdata_s = rdata_s | ({DATA_WIDTH{hit_ctrl_s}} & status_s);
    // rdata_s holds the addressed write register, so unselected bytes are kept.
    for (int b = 0; b < BE_W; b++) begin
      merge_s[b*8 +: 8] = bus.req_be[b] ? bus.req_wdata[b*8 +: 8] : rdata_s[b*8 +: 8];
    end
    snap_trig_s = accept_s & bus.req_write & hit_ctrl_s & bus.req_be[0] & bus.req_wdata[0];
    clr_s       = accept_s & bus.req_write & hit_ctrl_s & bus.req_be[0] & bus.req_wdata[1];
  end

  // Handshake FSM and registered response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= '0;
      rsp_error_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_r     <= ST_RESP;
            req_ready_r <= 1'b0;
            rsp_valid_r <= 1'b1;
            rsp_rdata_r <= (bus.req_write || oor_s) ? '0 : rdata_s;
            rsp_error_r <= oor_s;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            state_r     <= ST_IDLE;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          req_ready_r <= 1'b1;
          rsp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Write registers, strobes, snapshot capture and sticky error tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        wr_reg_r[i] <= '0;
        snap_r[i]   <= '0;
      end
      strobe_r  <= '0;
      sticky_r  <= 1'b0;
      err_cnt_r <= 8'd0;
    end else begin
      strobe_r <= (accept_s && bus.req_write) ? wsel_s : '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (accept_s && bus.req_write && wsel_s[i]) begin
          wr_reg_r[i] <= merge_s;
        end
        if (snap_trig_s) begin
          snap_r[i] <= user_data_in[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      if (clr_s) begin
        sticky_r  <= 1'b0;
        err_cnt_r <= 8'd0;
      end else if (accept_s && oor_s) begin
        sticky_r <= 1'b1;
        if (err_cnt_r != 8'hFF) begin
          err_cnt_r <= err_cnt_r + 8'd1;
        end
      end
    end
  end

  assign bus.req_ready = req_ready_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_rdata = rsp_rdata_r;
  assign bus.rsp_error = rsp_error_r;
  assign user_wr_strobe = strobe_r;

endmodule

// File: tb/tb_hdlverifier_jtag_register_bank.sv
// Directed scoreboard bench for hdlverifier_jtag_register_bank (SNAP_MODE=1).
module tb_hdlverifier_jtag_register_bank;
  localparam int DW = 32;
  localparam int NR = 4;
  localparam int AW = 5;
  localparam int BW = DW / 8;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
  } rsp_t;

  logic clk = 1'b0;
  logic reset;
  logic [NR*DW-1:0] user_data_in;
  logic [NR*DW-1:0] user_data_out;
  logic [NR-1:0]    user_wr_strobe;
  rsp_t sb[$];
  int pass_cnt = 0;
  int total_cnt = 0;

  hdlverifier_jtag_register_bank_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  hdlverifier_jtag_register_bank #(
    .DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW), .SNAP_MODE(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .user_data_in(user_data_in),
    .user_data_out(user_data_out),
    .user_wr_strobe(user_wr_strobe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [NR*DW-1:0] obs, input logic [NR*DW-1:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (bus.req_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("req_ready_before_req", bus.req_ready, 1'b1);
  endtask

  task automatic pop_check(input string tag);
    rsp_t e;
    e = sb.pop_front();
    check({tag, "_rdata"}, bus.rsp_rdata, e.rdata);
    check({tag, "_error"}, bus.rsp_error, e.err);
  endtask

  // Full transaction with rsp_ready held high: response and strobe at T+1, idle at T+2.
  task automatic do_req(input string tag, input logic wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, input logic [BW-1:0] be,
                        input logic [DW-1:0] exp_rd, input logic exp_err,
                        input logic [NR-1:0] exp_stb);
    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    bus.req_be    = be;
    sb.push_back({exp_rd, exp_err});
    tick();
    bus.req_valid = 1'b0;
    check({tag, "_rsp_valid"}, bus.rsp_valid, 1'b1);
    check({tag, "_strobe"}, user_wr_strobe, exp_stb);
    pop_check(tag);
    tick();
    check({tag, "_strobe_clear"}, user_wr_strobe, '0);
    check({tag, "_rsp_done"}, bus.rsp_valid, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    user_data_in  = '0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_be    = '0;
    bus.rsp_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    check("reset_req_ready", bus.req_ready, 1'b1);
    check("reset_rsp_valid", bus.rsp_valid, 1'b0);
    check("reset_user_data_out", user_data_out, '0);
    check("reset_strobe", user_wr_strobe, '0);
    do_req("status_reset", 1'b0, 5'd8, 32'h0, 4'h0, 32'h0, 1'b0, 4'b0000);

    // Byte-enable merge over an existing value.
    do_req("wr_full_ch1", 1'b1, 5'd1, 32'h11223344, 4'hF, 32'h0, 1'b0, 4'b0010);
    check("ch1_full", user_data_out[1*DW +: DW], 32'h11223344);
    do_req("wr_be_ch1", 1'b1, 5'd1, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0, 4'b0010);
    check("ch1_merged", user_data_out[1*DW +: DW], 32'h11BB33DD);
    do_req("rd_ch1", 1'b0, 5'd1, 32'h0, 4'h0, 32'h11BB33DD, 1'b0, 4'b0000);
    do_req("wr_be0_ch0", 1'b1, 5'd0, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0, 4'b0001);
    check("ch0_unchanged", user_data_out[0*DW +: DW], 32'h0);
    do_req("wr_ch3", 1'b1, 5'd3, 32'h0BADF00D, 4'hF, 32'h0, 1'b0, 4'b1000);
    check("ch3_written", user_data_out[3*DW +: DW], 32'h0BADF00D);
    do_req("wr_input_reg", 1'b1, 5'd5, 32'h12345678, 4'hF, 32'h0, 1'b0, 4'b0000);

    // Coherent snapshot, then inputs change underneath it.
    for (int i = 0; i < NR; i++) user_data_in[i*DW +: DW] = 32'h10 + 32'(i);
    do_req("wr_ctrl_snap", 1'b1, 5'd8, 32'h1, 4'h1, 32'h0, 1'b0, 4'b0000);
    for (int i = 0; i < NR; i++) user_data_in[i*DW +: DW] = 32'hFF;
    for (int i = 0; i < NR; i++) begin
      do_req("rd_snap", 1'b0, 5'(NR + i), 32'h0, 4'h0, 32'h10 + 32'(i), 1'b0, 4'b0000);
    end

    // Out-of-range accesses and sticky error reporting.
    for (int i = 0; i < 3; i++) begin
      do_req("rd_oor20", 1'b0, 5'd20, 32'h0, 4'h0, 32'h0, 1'b1, 4'b0000);
    end
    do_req("status_3err", 1'b0, 5'd8, 32'h0, 4'h0, 32'h00000302, 1'b0, 4'b0000);
    do_req("wr_ctrl_clr_be0", 1'b1, 5'd8, 32'h2, 4'h0, 32'h0, 1'b0, 4'b0000);
    do_req("status_not_cleared", 1'b0, 5'd8, 32'h0, 4'h0, 32'h00000302, 1'b0, 4'b0000);
    do_req("wr_ctrl_clr", 1'b1, 5'd8, 32'h2, 4'h1, 32'h0, 1'b0, 4'b0000);
    do_req("status_cleared", 1'b0, 5'd8, 32'h0, 4'h0, 32'h0, 1'b0, 4'b0000);
    do_req("wr_oor9", 1'b1, 5'd9, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, 4'b0000);
    do_req("status_1err", 1'b0, 5'd8, 32'h0, 4'h0, 32'h00000102, 1'b0, 4'b0000);
    for (int i = 0; i < 260; i++) begin
      do_req("rd_oor31", 1'b0, 5'd31, 32'h0, 4'h0, 32'h0, 1'b1, 4'b0000);
    end
    do_req("status_sat", 1'b0, 5'd8, 32'h0, 4'h0, 32'h0000FF02, 1'b0, 4'b0000);
    do_req("wr_ctrl_clr2", 1'b1, 5'd8, 32'h2, 4'h1, 32'h0, 1'b0, 4'b0000);

    // Backpressure: response held, a second request must be ignored.
    bus.rsp_ready = 1'b0;
    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 5'd1;
    sb.push_back({32'h11BB33DD, 1'b0});
    tick();
    bus.req_write = 1'b1;
    bus.req_addr  = 5'd0;
    bus.req_wdata = 32'hCAFEF00D;
    bus.req_be    = 4'hF;
    for (int i = 0; i < 5; i++) begin
      check("hold_rsp_valid", bus.rsp_valid, 1'b1);
      check("hold_rsp_rdata", bus.rsp_rdata, 32'h11BB33DD);
      check("hold_req_ready", bus.req_ready, 1'b0);
      check("hold_no_strobe", user_wr_strobe, '0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    pop_check("held_rsp");
    tick();
    bus.req_valid = 1'b0;
    check("release_rsp_valid", bus.rsp_valid, 1'b0);
    check("release_req_ready", bus.req_ready, 1'b1);
    check("ignored_write_ch0", user_data_out[0*DW +: DW], 32'h0);

    // Reset while a response is pending drops it and clears state.
    do_req("wr_ch2", 1'b1, 5'd2, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 4'b0100);
    bus.rsp_ready = 1'b0;
    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 5'd2;
    tick();
    bus.req_valid = 1'b0;
    check("pre_reset_rsp_valid", bus.rsp_valid, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.rsp_ready = 1'b1;
    check("midreset_rsp_valid", bus.rsp_valid, 1'b0);
    check("midreset_req_ready", bus.req_ready, 1'b1);
    check("midreset_user_data_out", user_data_out, '0);
    check("midreset_strobe", user_wr_strobe, '0);
    do_req("rd_snap_after_reset", 1'b0, 5'd4, 32'h0, 4'h0, 32'h0, 1'b0, 4'b0000);
    do_req("status_after_reset", 1'b0, 5'd8, 32'h0, 4'h0, 32'h0, 1'b0, 4'b0000);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
